// File: rtl/uart_cmd_link.sv
// 8N1 UART link: sends the command byte on change or keep-alive, receives status bytes.
// Receive path is built only when UART_CMD_RX_EN is defined; otherwise rec/rec_valid/frame_err stay 0.
//
// state    | meaning
// IDLE     | line high, waiting for a reason to send (tx) / a low level (rx)
// START    | start bit: tx drives 0; rx waits half a bit, then rejects glitches
// DATA     | eight data bits, LSB first
// STOP     | stop bit: tx drives 1; rx checks the line is high
module uart_cmd_link #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int REFRESH_CLKS = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic       cmd_en,
    input  logic       rx,
    output logic       tx,
    output logic       tx_busy,
    output logic [7:0] rec,
    output logic       rec_valid,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int RW = $clog2(REFRESH_CLKS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CLKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_idx, tx_idx_n;
    logic [7:0]      shift, shift_n;
    logic [7:0]      last_sent, last_sent_n;
    logic            first, first_n;
    logic [RW-1:0]   ref_cnt, ref_cnt_n;
    logic            tx_go;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            shift     <= '0;
            last_sent <= '0;
            first     <= 1'b1;
            ref_cnt   <= '0;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_idx    <= tx_idx_n;
            shift     <= shift_n;
            last_sent <= last_sent_n;
            first     <= first_n;
            ref_cnt   <= ref_cnt_n;
        end
    end

    assign tx_go = cmd_en && (first || (cmd != last_sent) || (ref_cnt == REF_LAST));

    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = tx_cnt;
        tx_idx_n    = tx_idx;
        shift_n     = shift;
        last_sent_n = last_sent;
        first_n     = first;
        ref_cnt_n   = (ref_cnt == REF_LAST) ? ref_cnt : ref_cnt + RW'(1);
        case (tx_state)
            S_IDLE: begin
                if (tx_go) begin
                    tx_state_n  = S_START;
                    tx_cnt_n    = BIT_LAST;
                    shift_n     = cmd;
                    last_sent_n = cmd;
                    first_n     = 1'b0;
                    ref_cnt_n   = '0;
                end
            end
            S_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = BIT_LAST;
                    tx_idx_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = BIT_LAST;
                    if (tx_idx == 3'd7) tx_state_n = S_STOP;
                    else                tx_idx_n   = tx_idx + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt == '0) tx_state_n = S_IDLE;
                else              tx_cnt_n   = tx_cnt - CW'(1);
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // Decoded straight from reset-cleared state so tx goes high the moment rst falls.
    always_comb begin
        tx = 1'b1;
        case (tx_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift[tx_idx];
            default: tx = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state != S_IDLE);

`ifdef UART_CMD_RX_EN
    state_t        rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_sh, rx_sh_n;
    logic [7:0]    rec_r, rec_n;
    logic          valid_r, valid_n;
    logic          err_r, err_n;
    logic          rx_s1, rx_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rec_r    <= '0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_sh    <= rx_sh_n;
            rec_r    <= rec_n;
            valid_r  <= valid_n;
            err_r    <= err_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_sh_n    = rx_sh;
        rec_n      = rec_r;
        valid_n    = 1'b0;
        err_n      = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (!rx_s2) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = HALF_LAST;
                end
            end
            S_START: begin
                if (rx_cnt == '0) begin
                    if (rx_s2) begin
                        rx_state_n = S_IDLE;
                    end else begin
                        rx_state_n = S_DATA;
                        rx_cnt_n   = BIT_LAST;
                        rx_idx_n   = '0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt == '0) begin
                    rx_sh_n  = {rx_s2, rx_sh[7:1]};
                    rx_cnt_n = BIT_LAST;
                    if (rx_idx == 3'd7) rx_state_n = S_STOP;
                    else                rx_idx_n   = rx_idx + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_n = S_IDLE;
                    if (rx_s2) begin
                        rec_n   = rx_sh;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CW'(1);
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    assign rec       = rec_r;
    assign rec_valid = valid_r;
    assign frame_err = err_r;
`else
    logic unused_rx;
    assign unused_rx = rx;
    assign rec       = 8'h00;
    assign rec_valid = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule
